// File: rtl/gray_ticket_pkg.sv
// gray_ticket_pkg: shared helpers for the Gray ticket arbiter (index-width calc, bin2gray).
package gray_ticket_pkg;
  localparam int MAX_W = 32;
  // Width of a binary requester index, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // Callers truncate the result to their own ticket width.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray_ticket_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   i_elig   : eligible requester mask
//   i_ptr    : index where the search starts (wraps modulo NUM_REQ)
//   o_onehot : one-hot pick, zero when nothing is eligible
//   o_idx    : binary index of the pick, zero when nothing is eligible
module rr_pick
  import gray_ticket_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IW-1:0]      o_idx
);
  int   w_k;
  logic w_found;
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_k      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = (int'(i_ptr) + i) % NUM_REQ;
      if (!w_found && i_elig[w_k]) begin
        w_found       = 1'b1;
        o_onehot[w_k] = 1'b1;
        o_idx         = IW'(w_k);
      end
    end
  end
endmodule

// File: rtl/gray_ticket_arbiter.sv
// gray_ticket_arbiter: round-robin arbiter issuing a Gray-coded ticket with each one-cycle grant.
//   clk, rst   : clock, synchronous active-high reset
//   req        : level requests, held until granted
//   gnt        : registered one-hot grant pulse
//   gnt_id     : binary index of the granted requester
//   ticket     : Gray-coded ticket, holds its last value when idle
//   ticket_vld : high exactly when gnt is non-zero
//   hold       : only with GRAY_TICKET_ARB_HOLD_EN; freezes issue while high
module gray_ticket_arbiter
  import gray_ticket_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
`ifdef GRAY_TICKET_ARB_HOLD_EN
  input  logic                        hold,
`endif
  output logic [NUM_REQ-1:0]          gnt,
  output logic [idx_w(NUM_REQ)-1:0]   gnt_id,
  output logic [DATA_WIDTH-1:0]       ticket,
  output logic                        ticket_vld
);
  localparam int IW = idx_w(NUM_REQ);
  logic [NUM_REQ-1:0]    r_gnt;
  logic [IW-1:0]         r_gnt_id;
  logic [IW-1:0]         r_ptr;
  logic [DATA_WIDTH-1:0] r_ticket;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic                  r_vld;
  logic                  w_hold;
  logic [NUM_REQ-1:0]    w_onehot;
  logic [IW-1:0]         w_idx;
  logic                  w_issue;
  logic [DATA_WIDTH-1:0] w_gray;
`ifdef GRAY_TICKET_ARB_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif
  // A requester whose grant pulse is currently out sits this cycle out.
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_elig   (req & ~r_gnt),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );
  assign w_issue = !w_hold && (|w_onehot);
  assign w_gray  = DATA_WIDTH'(bin2gray(MAX_W'(r_cnt)));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_ticket <= '0;
      r_vld    <= 1'b0;
      r_cnt    <= '0;
      r_ptr    <= '0;
    end else begin
      r_gnt    <= w_issue ? w_onehot : '0;
      r_gnt_id <= w_issue ? w_idx : '0;
      r_vld    <= w_issue;
      if (w_issue) begin
        r_ticket <= w_gray;
        r_cnt    <= r_cnt + 1'b1;
        r_ptr    <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end
  assign gnt        = r_gnt;
  assign gnt_id     = r_gnt_id;
  assign ticket     = r_ticket;
  assign ticket_vld = r_vld;
endmodule

// File: tb/tb_gray_ticket_arbiter.sv
// tb_gray_ticket_arbiter: directed self-checking bench for gray_ticket_arbiter (NUM_REQ=4, DATA_WIDTH=4).
module tb_gray_ticket_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic [3:0] ticket;
  logic       ticket_vld;
`ifdef GRAY_TICKET_ARB_HOLD_EN
  logic       hold = 1'b0;
`endif
  int checks = 0;
  int errors = 0;
  logic [3:0] tk [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                          4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  always #5 clk = ~clk;

  gray_ticket_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
`ifdef GRAY_TICKET_ARB_HOLD_EN
    .hold       (hold),
`endif
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .ticket     (ticket),
    .ticket_vld (ticket_vld)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 4'b1111;
    step();
    step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id got %0d exp 0", gnt_id); end
    checks++; if (ticket !== 4'b0000) begin errors++; $display("FAIL reset_ticket got %b exp 0000", ticket); end
    checks++; if (ticket_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", ticket_vld); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (gnt !== ((c % 2 == 0) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL single_gnt cycle %0d got %b", c, gnt); end
      checks++;
      if (ticket_vld !== (c % 2 == 0)) begin errors++; $display("FAIL single_vld cycle %0d got %b", c, ticket_vld); end
      checks++;
      if (ticket !== tk[c/2]) begin errors++; $display("FAIL single_ticket cycle %0d got %b exp %b", c, ticket, tk[c/2]); end
      checks++;
      if (gnt_id !== 2'd0) begin errors++; $display("FAIL single_gnt_id cycle %0d got %0d exp 0", c, gnt_id); end
    end
  endtask

  task automatic test_all_req;
    int ids [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (gnt !== 4'(1 << ids[c])) begin errors++; $display("FAIL all_gnt cycle %0d got %b exp %b", c, gnt, 4'(1 << ids[c])); end
      checks++;
      if (gnt_id !== 2'(ids[c])) begin errors++; $display("FAIL all_gnt_id cycle %0d got %0d exp %0d", c, gnt_id, ids[c]); end
      checks++;
      if (ticket !== tk[c]) begin errors++; $display("FAIL all_ticket cycle %0d got %b exp %b", c, ticket, tk[c]); end
      checks++;
      if (ticket_vld !== 1'b1) begin errors++; $display("FAIL all_vld cycle %0d got %b exp 1", c, ticket_vld); end
    end
  endtask

  task automatic test_wrap;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      step();
      checks++;
      if (ticket !== tk[c]) begin errors++; $display("FAIL wrap_ticket grant %0d got %b exp %b", c + 1, ticket, tk[c]); end
      checks++;
      if (gnt !== 4'(1 << (c % 4))) begin errors++; $display("FAIL wrap_gnt grant %0d got %b exp %b", c + 1, gnt, 4'(1 << (c % 4))); end
    end
  endtask

  task automatic test_rst_mid;
    do_reset();
    req = 4'b1111;
    repeat (3) step();
    rst = 1'b1;
    step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt got %b exp 0000", gnt); end
    checks++; if (ticket_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld got %b exp 0", ticket_vld); end
    checks++; if (ticket !== 4'b0000) begin errors++; $display("FAIL rstmid_ticket got %b exp 0000", ticket); end
    rst = 1'b0;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_first_gnt got %b exp 0001", gnt); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL rstmid_first_id got %0d exp 0", gnt_id); end
    checks++; if (ticket !== 4'b0000) begin errors++; $display("FAIL rstmid_first_ticket got %b exp 0000", ticket); end
  endtask

  task automatic test_idle;
    do_reset();
    req = 4'b1111;
    repeat (3) step();
    req = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (ticket_vld !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL idle_vld cycle %0d got vld %b gnt %b exp 0", c, ticket_vld, gnt); end
      checks++;
      if (ticket !== 4'b0011) begin errors++; $display("FAIL idle_ticket cycle %0d got %b exp 0011", c, ticket); end
    end
    req = 4'b0100;
    step();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL idle_next_gnt got %b exp 0100", gnt); end
    checks++; if (gnt_id !== 2'd2) begin errors++; $display("FAIL idle_next_id got %0d exp 2", gnt_id); end
    checks++; if (ticket !== 4'b0010) begin errors++; $display("FAIL idle_next_ticket got %b exp 0010", ticket); end
  endtask

`ifdef GRAY_TICKET_ARB_HOLD_EN
  task automatic test_hold;
    do_reset();
    req = 4'b0001;
    step();
    hold = 1'b1;
    req = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (gnt !== 4'b0000 || ticket_vld !== 1'b0) begin errors++; $display("FAIL hold_gnt cycle %0d got gnt %b vld %b exp 0", c, gnt, ticket_vld); end
      checks++;
      if (ticket !== 4'b0000) begin errors++; $display("FAIL hold_ticket cycle %0d got %b exp 0000", c, ticket); end
    end
    hold = 1'b0;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL hold_release_gnt got %b exp 0010", gnt); end
    checks++; if (gnt_id !== 2'd1) begin errors++; $display("FAIL hold_release_id got %0d exp 1", gnt_id); end
    checks++; if (ticket !== 4'b0001) begin errors++; $display("FAIL hold_release_ticket got %b exp 0001", ticket); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_wrap();
    test_rst_mid();
    test_idle();
`ifdef GRAY_TICKET_ARB_HOLD_EN
    test_hold();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_ticket_arbiter.md
GRAY_TICKET_ARBITER -- requirements
Module: gray_ticket_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, ticket width in bits (>=2).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester ticket request, level, held until granted.
REQ-006 SHALL have port gnt  output  NUM_REQ  one-hot grant pulse, one cycle.
REQ-007 SHALL have port gnt_id  output  clog2(NUM_REQ)  binary index of the granted requester, valid with ticket_vld.
REQ-008 SHALL have port ticket  output  DATA_WIDTH  Gray-coded ticket issued with the grant.
REQ-009 SHALL have port ticket_vld  output  1  high exactly when gnt is non-zero.

Function
REQ-010 SHALL sample req at each edge and register gnt, gnt_id, ticket and ticket_vld: one cycle latency from sampled req to grant.
REQ-011 SHALL issue at most one grant per cycle.
REQ-012 SHALL mask a requester whose gnt bit is currently high from eligibility, so a held req never receives back-to-back grants; the minimum repeat interval per requester is 2 cycles.
REQ-013 SHALL pick the eligible requester using round-robin: the search starts at pointer ptr and wraps modulo NUM_REQ.
REQ-014 SHALL set ptr to (granted index + 1) mod NUM_REQ after a grant; ptr SHALL hold when there is no grant.
REQ-015 SHALL keep a binary issue counter cnt of DATA_WIDTH bits and drive ticket = cnt ^ (cnt >> 1) for the grant, then increment cnt.
REQ-016 SHALL wrap cnt from 2^DATA_WIDTH-1 to 0 without a gap or stall, so successive tickets always differ in exactly one bit.
REQ-017 SHALL hold cnt and drive gnt, gnt_id and ticket_vld to 0 in cycles with no eligible request; ticket SHALL hold its last value.

Reset
REQ-018 SHALL on rst clear gnt, gnt_id, ticket, ticket_vld, cnt to 0 and ptr to 0 (requester 0 highest priority).
REQ-019 SHALL let rst override all other inputs, including mid-sequence, so that no grant appears in the cycle after rst is sampled high.

Configuration
REQ-020 SHALL with macro GRAY_TICKET_ARB_HOLD_EN defined add input hold (1 bit); while hold is sampled high no grant is issued and cnt and ptr freeze, and after hold falls the grant is based on the req sampled at that edge.
REQ-021 SHALL without GRAY_TICKET_ARB_HOLD_EN omit the hold port and behave as if hold = 0.

Structure
REQ-022 SHALL place the bin2gray function and the clog2-based index-width constant in shared package gray_ticket_pkg.
REQ-023 SHALL implement round-robin selection in combinational sub-module rr_pick (inputs eligible mask and ptr; outputs one-hot and index).

Verification (NUM_REQ=4, DATA_WIDTH=4)
REQ-024 SHALL cover: after rst, req=0001 held -> gnt=0001 every 2nd cycle, tickets 0000,0001,0011,0010,0110.
REQ-025 SHALL cover: req=1111 held -> gnt order 0,1,2,3,0 on consecutive cycles, tickets 0000,0001,0011,0010,0110, gnt_id 0,1,2,3,0.
REQ-026 SHALL cover: 17 consecutive grants -> the 16th ticket is 1000 and the 17th is 0000 (wrap, single-bit change).
REQ-027 SHALL cover: rst asserted with req=1111 after 3 grants -> gnt=0 in the next cycle, and the first grant after release goes to requester 0 with ticket 0000.
REQ-028 SHALL cover: req=0000 for 5 cycles between grants -> ticket_vld=0 and ticket held throughout, and the next ticket is consecutive.
REQ-029 SHALL cover: with GRAY_TICKET_ARB_HOLD_EN, hold=1 for 3 cycles with req=0110 -> no grants, then grant to 1 with the ticket following the last one issued.
